// File: rtl/pattern_sequencer.sv
// Test-pattern mode controller: latches step/select requests and applies them only
// on frame boundaries, with an optional auto-cycle that dwells a programmable number of frames.
module pattern_sequencer #(
  parameter int unsigned NUM_MODES = 3,
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        hcnt,
  input  logic [11:0]        vcnt,
  input  logic               next_req,
  input  logic               set_valid,
  input  logic [3:0]         set_mode,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell_frames,
  output logic [3:0]         mode,
  output logic               pending,
  output logic               mode_chg,
  output logic               req_err,
  output logic [FCNT_W-1:0]  frame_cnt
);

  typedef enum logic {HOLD, AUTO} state_t;

  localparam logic [3:0] LAST_MODE = 4'(NUM_MODES - 1);
  localparam logic [4:0] MODE_LIM  = 5'(NUM_MODES);

  state_t             r_state;
  logic [3:0]         r_pend_mode;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_frame_tick;
  logic               w_set_ok;
  logic [DWELL_W-1:0] w_dwell_lim;
  logic [DWELL_W:0]   w_dwell_inc;
  logic               w_dwell_done;
  logic [DWELL_W-1:0] w_dwell_sat;
  logic [3:0]         w_step_base;

  // Compare-then-reset keeps the wrap free of any intermediate overflow.
  function automatic logic [3:0] inc_mode(input logic [3:0] m);
    return (m >= LAST_MODE) ? 4'd0 : m + 4'd1;
  endfunction

  always_comb begin
    w_frame_tick = (hcnt == '0) && (vcnt == '0);
    w_set_ok     = ({1'b0, set_mode} < MODE_LIM);
    w_dwell_lim  = (dwell_frames == '0) ? DWELL_W'(1) : dwell_frames;
    w_dwell_inc  = {1'b0, r_dwell} + (DWELL_W + 1)'(1);
    w_dwell_done = (w_dwell_inc >= {1'b0, w_dwell_lim});
    w_dwell_sat  = (&r_dwell) ? r_dwell : w_dwell_inc[DWELL_W-1:0];
    w_step_base  = pending ? r_pend_mode : mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HOLD;
      r_pend_mode <= '0;
      r_dwell     <= '0;
      mode        <= '0;
      pending     <= 1'b0;
      mode_chg    <= 1'b0;
      req_err     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      mode_chg <= 1'b0;
      req_err  <= 1'b0;

      if (w_frame_tick) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
        if (pending) begin
          mode     <= r_pend_mode;
          pending  <= 1'b0;
          r_dwell  <= '0;
          mode_chg <= 1'b1;
        end else if (r_state == AUTO) begin
          if (w_dwell_done) begin
            mode     <= inc_mode(mode);
            r_dwell  <= '0;
            mode_chg <= 1'b1;
          end else begin
            r_dwell <= w_dwell_sat;
          end
        end
      end

      case (r_state)
        HOLD: if (auto_en) begin
          r_state <= AUTO;
          r_dwell <= '0;
        end
        AUTO: if (!auto_en) begin
          r_state <= HOLD;
          r_dwell <= '0;
        end
        default: r_state <= HOLD;
      endcase

      // Capture is evaluated last so a request arriving with the tick stays pending.
      if (set_valid) begin
        if (w_set_ok) begin
          r_pend_mode <= set_mode;
          pending     <= 1'b1;
        end else begin
          req_err <= 1'b1;
        end
      end else if (next_req) begin
        r_pend_mode <= inc_mode(w_step_base);
        pending     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: per-cycle scoreboard against a behavioural
// model, a table of request scenarios, and hand-written frame-boundary corner cases.
module tb_pattern_sequencer;

  localparam int NM    = 3;
  localparam int DW    = 8;
  localparam int FW    = 16;
  localparam int H_TOT = 8;
  localparam int V_TOT = 4;
  localparam int BOUND = 2 * H_TOT * V_TOT;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   hcnt;
  logic [11:0]   vcnt;
  logic          next_req;
  logic          set_valid;
  logic [3:0]    set_mode;
  logic          auto_en;
  logic [DW-1:0] dwell_frames;
  logic [3:0]    mode;
  logic          pending;
  logic          mode_chg;
  logic          req_err;
  logic [FW-1:0] frame_cnt;

  always #5 clk = ~clk;

  pattern_sequencer #(.NUM_MODES(NM), .DWELL_W(DW), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .next_req(next_req), .set_valid(set_valid), .set_mode(set_mode),
    .auto_en(auto_en), .dwell_frames(dwell_frames),
    .mode(mode), .pending(pending), .mode_chg(mode_chg),
    .req_err(req_err), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int mode;
    bit pending;
    bit chg;
    bit err;
    int fcnt;
  } exp_t;

  typedef struct {
    string name;
    int    nreq;
    bit    sv;
    int    smode;
    bit    sv_req;
    int    exp_mode;
    bit    exp_err;
    int    exp_chg;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int checks = 0, errors = 0, cyc = 0, chg_seen = 0;

  int m_mode = 0, m_pmode = 0, m_dwell = 0, m_fcnt = 0;
  bit m_pend = 0, m_chg = 0, m_err = 0, m_auto = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Next-state model for the inputs currently applied; result is what the DUT shows after the edge.
  task automatic model_step(output exp_t e);
    bit tick;
    int lim, n_mode, n_pmode, n_dwell, n_fcnt;
    bit n_pend, n_auto, n_chg, n_err;
    tick = (hcnt == 0) && (vcnt == 0);
    if (rst) begin
      m_mode = 0; m_pmode = 0; m_dwell = 0; m_fcnt = 0;
      m_pend = 0; m_chg = 0; m_err = 0; m_auto = 0;
    end else begin
      n_mode = m_mode; n_pmode = m_pmode; n_dwell = m_dwell; n_fcnt = m_fcnt;
      n_pend = m_pend; n_auto = m_auto; n_chg = 0; n_err = 0;
      lim = (dwell_frames == 0) ? 1 : int'(dwell_frames);
      if (tick) begin
        n_fcnt = (m_fcnt + 1) % (1 << FW);
        if (m_pend) begin
          n_mode = m_pmode; n_pend = 0; n_dwell = 0; n_chg = 1;
        end else if (m_auto && (m_dwell + 1 >= lim)) begin
          n_mode = (m_mode + 1) % NM; n_dwell = 0; n_chg = 1;
        end else if (m_auto && m_dwell < (1 << DW) - 1) begin
          n_dwell = m_dwell + 1;
        end
      end
      if (auto_en != m_auto) begin
        n_auto = auto_en; n_dwell = 0;
      end
      if (set_valid) begin
        if (set_mode < NM) begin
          n_pmode = set_mode; n_pend = 1;
        end else begin
          n_err = 1;
        end
      end else if (next_req) begin
        n_pmode = ((m_pend ? m_pmode : m_mode) + 1) % NM;
        n_pend  = 1;
      end
      m_mode = n_mode; m_pmode = n_pmode; m_dwell = n_dwell; m_fcnt = n_fcnt;
      m_pend = n_pend; m_auto = n_auto; m_chg = n_chg; m_err = n_err;
    end
    e.mode = m_mode; e.pending = m_pend; e.chg = m_chg; e.err = m_err; e.fcnt = m_fcnt;
  endtask

  task automatic cycle();
    exp_t e;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (mode !== 4'(e.mode) || pending !== e.pending || mode_chg !== e.chg ||
        req_err !== e.err || frame_cnt !== FW'(e.fcnt)) begin
      errors++;
      $display("FAIL cycle %0d: got mode=%0d pend=%0b chg=%0b err=%0b fcnt=%0d, expected mode=%0d pend=%0b chg=%0b err=%0b fcnt=%0d",
               cyc, mode, pending, mode_chg, req_err, frame_cnt,
               e.mode, e.pending, e.chg, e.err, e.fcnt);
    end
    if (mode_chg === 1'b1) chg_seen++;
    cyc++;
    next_req  = 1'b0;
    set_valid = 1'b0;
    if (hcnt == 11'(H_TOT - 1)) begin
      hcnt = '0;
      vcnt = (vcnt == 12'(V_TOT - 1)) ? '0 : vcnt + 12'd1;
    end else begin
      hcnt = hcnt + 11'd1;
    end
  endtask

  // Runs until the edge that consumes a frame tick has passed.
  task automatic wait_tick();
    bit hit = 0;
    for (int i = 0; i < BOUND && !hit; i++) begin
      hit = (hcnt == 0) && (vcnt == 0);
      cycle();
    end
    chk("tick_reached", int'(hit), 1);
  endtask

  // Stops with the tick value applied but not yet clocked.
  task automatic to_tick_cycle();
    for (int i = 0; i < BOUND && !(hcnt == 0 && vcnt == 0); i++) cycle();
    chk("tick_cycle_reached", int'(hcnt == 0 && vcnt == 0), 1);
  endtask

  task automatic go_mid();
    for (int i = 0; i < BOUND && !(hcnt == 3 && vcnt == 2); i++) cycle();
    chk("mid_frame_reached", int'(hcnt == 3 && vcnt == 2), 1);
  endtask

  initial begin
    vt[0] = '{"three_steps",    3, 0,  0, 0, 0, 0, 1};
    vt[1] = '{"one_step",       1, 0,  0, 0, 1, 0, 1};
    vt[2] = '{"set_oor5",       0, 1,  5, 0, 1, 1, 0};
    vt[3] = '{"set2_with_step", 0, 1,  2, 1, 2, 0, 1};
    vt[4] = '{"set0",           0, 1,  0, 0, 0, 0, 1};
    vt[5] = '{"two_steps",      2, 0,  0, 0, 2, 0, 1};
    vt[6] = '{"set_oor15",      0, 1, 15, 0, 2, 1, 0};

    rst = 1'b1; hcnt = 11'd2; vcnt = 12'd1;
    next_req = 1'b0; set_valid = 1'b0; set_mode = '0;
    auto_en = 1'b0; dwell_frames = 8'd2;
    repeat (3) cycle();
    rst = 1'b0;
    chk("reset_mode", int'(mode), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);

    chg_seen = 0;
    repeat (3) wait_tick();
    chk("idle_frame_cnt", int'(frame_cnt), 3);
    chk("idle_mode", int'(mode), 0);
    chk("idle_mode_chg_count", chg_seen, 0);

    foreach (vt[k]) begin
      go_mid();
      chg_seen = 0;
      if (vt[k].sv) begin
        set_valid = 1'b1;
        set_mode  = 4'(vt[k].smode);
        next_req  = vt[k].sv_req;
        cycle();
        chk({vt[k].name, "_req_err"}, int'(req_err), int'(vt[k].exp_err));
        chk({vt[k].name, "_pending"}, int'(pending), int'(!vt[k].exp_err));
      end
      for (int j = 0; j < vt[k].nreq; j++) begin
        next_req = 1'b1;
        cycle();
      end
      if (vt[k].nreq > 0) chk({vt[k].name, "_pending"}, int'(pending), 1);
      wait_tick();
      chk({vt[k].name, "_mode"}, int'(mode), vt[k].exp_mode);
      chk({vt[k].name, "_pending_after"}, int'(pending), 0);
      cycle();
      chk({vt[k].name, "_chg_count"}, chg_seen, vt[k].exp_chg);
    end

    go_mid();
    set_valid = 1'b1; set_mode = 4'd0;
    cycle();
    to_tick_cycle();
    set_valid = 1'b1; set_mode = 4'd1;
    cycle();
    chk("coincide_mode_now", int'(mode), 0);
    chk("coincide_pending", int'(pending), 1);
    chk("coincide_chg", int'(mode_chg), 1);
    wait_tick();
    chk("coincide_mode_next", int'(mode), 1);
    chk("coincide_pending_next", int'(pending), 0);

    go_mid();
    next_req = 1'b1;
    cycle();
    chk("prereset_pending", int'(pending), 1);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midpend_reset_mode", int'(mode), 0);
    chk("midpend_reset_pending", int'(pending), 0);
    chk("midpend_reset_chg", int'(mode_chg), 0);
    chk("midpend_reset_err", int'(req_err), 0);
    chk("midpend_reset_fcnt", int'(frame_cnt), 0);
    chg_seen = 0;
    wait_tick();
    chk("discarded_req_mode", int'(mode), 0);
    chk("discarded_req_chg", chg_seen, 0);

    go_mid();
    auto_en = 1'b1; dwell_frames = 8'd2;
    cycle();
    for (int t = 1; t <= 6; t++) begin
      wait_tick();
      if (t == 1) chk("auto_tick1", int'(mode), 0);
      if (t == 2) chk("auto_tick2", int'(mode), 1);
      if (t == 4) chk("auto_tick4", int'(mode), 2);
      if (t == 6) chk("auto_tick6", int'(mode), 0);
    end
    dwell_frames = 8'd0;
    wait_tick();
    chk("dwell0_tick1", int'(mode), 1);
    wait_tick();
    chk("dwell0_tick2", int'(mode), 2);
    go_mid();
    auto_en = 1'b0;
    cycle();
    chg_seen = 0;
    repeat (2) wait_tick();
    chk("auto_off_mode", int'(mode), 2);
    chk("auto_off_chg", chg_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
